gp_register_file: RTL and testbench
===================================

GP_REGISTER_FILE -- requirements
Module: gp_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the register data width; legal values are 16 or more.
REQ-002 SHALL have parameter NUM_REGS, default 8, the register count; legal values are powers of two, 2 or more.
REQ-003 SHALL have parameter ADDR_W, default 3, the address width; it SHALL equal log2(NUM_REGS).
REQ-004 SHALL have parameter RESET_VALUE, default 32'h0000_0888, the reset contents of every register, truncated to WIDTH.
REQ-005 SHALL have ports:
  clock  input  1  sole clock; all state updates on posedge.
  reset  input  1  synchronous, active-high.
  wr_en  input  1  write request this cycle.
  wr_addr  input  ADDR_W  write target.
  wr_size  input  2  write mode: 00 full, 01 low16, 10 low8, 11 bits[15:8].
  wr_data  input  WIDTH  write data, right-aligned (bits 7:0 carry the byte in mode 11).
  rd_addr_a  input  ADDR_W  read port A address.
  rd_addr_b  input  ADDR_W  read port B address.
  rd_data_a  output  WIDTH  registered read data, port A.
  rd_data_b  output  WIDTH  registered read data, port B.
  lock_en  input  1  request to mark lock_addr busy.
  lock_addr  input  ADDR_W  register to lock.
  busy  output  NUM_REGS  per-register pending-write scoreboard.
  lock_err  output  1  one-cycle pulse: lock requested on an already busy register.

Function
REQ-006 SHALL commit a write at the posedge where wr_en=1; unselected bits of the target register SHALL hold.
REQ-007 SHALL, in mode 00, write all WIDTH bits.
REQ-008 SHALL, in mode 01, write bits[15:0] only.
REQ-009 SHALL, in mode 10, write bits[7:0] only.
REQ-010 SHALL, in mode 11, write wr_data[7:0] into bits[15:8] only.
REQ-011 SHALL register both read ports with 1-cycle latency: rd_data_x after posedge N reflects rd_addr_x sampled at posedge N.
REQ-012 SHALL give write-through on a same-cycle address match: the read returns the merged value the write produces, not the old value.
REQ-013 SHALL allow both read ports to access the same address at once, each returning identical data.
REQ-014 SHALL set busy[lock_addr] at the posedge where lock_en=1.
REQ-015 SHALL clear busy[wr_addr] at the posedge where wr_en=1 and the target is busy, in any write mode.
REQ-016 SHALL keep busy[n]=1 when lock and write target the same n in the same cycle (lock wins); the write data SHALL still commit.
REQ-017 SHALL pulse lock_err=1 for one cycle after a lock_en on a register with busy=1 not cleared by a same-cycle write; busy stays 1 and no other state changes.
REQ-018 SHALL keep lock_err=0 in every other cycle.
REQ-019 SHALL accept a write to a non-busy register normally; busy is unaffected.
REQ-020 SHALL ignore wr_addr, wr_size and wr_data when wr_en=0.
REQ-021 SHALL ignore lock_addr when lock_en=0.
REQ-022 SHALL hold all state when no request is active; read outputs still track their addresses.

Reset
REQ-023 SHALL, on a posedge with reset=1, load every register with RESET_VALUE.
REQ-024 SHALL, on a posedge with reset=1, clear busy, lock_err, rd_data_a and rd_data_b to 0.
REQ-025 SHALL give reset priority over a same-cycle write or lock, which SHALL be discarded.
REQ-026 SHALL, in the first cycle after reset deasserts, return RESET_VALUE on a read.
REQ-027 SHALL discard any outstanding locks on reset; there is no recovery.

Verification
REQ-028 Reset, then read regs 0 and 7 on A/B -> both rd_data = 0x0000_0888 one cycle later; busy = 0.
REQ-029 Write reg 3 = 0xDEAD_BEEF (mode 00) -> mode 10 0x11 -> mode 11 0x22 -> mode 01 0x3344 -> reads 0xDEAD_BEEF, 0xDEAD_BE11, 0xDEAD_2211, 0xDEAD_3344.
REQ-030 Same-cycle write reg 2 = 0x1234_5678 (mode 00) with rd_addr_a = rd_addr_b = 2 -> next cycle both = 0x1234_5678.
REQ-031 Lock reg 5 -> busy = 0x20.
REQ-032 Lock reg 5 again -> lock_err pulses 1 cycle, busy = 0x20.
REQ-033 Write reg 5 -> busy = 0x00.
REQ-034 Lock reg 5 with a same-cycle write reg 5 -> busy[5] = 1 and the data committed.
REQ-035 Assert reset alongside write reg 1 = 0xFFFF_FFFF and lock reg 1 -> reg 1 reads 0x0000_0888, busy = 0, lock_err = 0.
REQ-036 Re-elaborate with WIDTH=16, NUM_REGS=4 -> reset value 0x0888; mode 00 write 0xABCD reads 0xABCD.

Source files
------------

// File: rtl/gp_register_file.sv
// General-purpose register file: two registered read ports with write-through,
// sub-word write modes and a per-register busy scoreboard with lock error pulse.
module gp_register_file #(
  parameter int          WIDTH       = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_W      = 3,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0888
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [1:0]          wr_size,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [WIDTH-1:0]    rd_data_a,
  output logic [WIDTH-1:0]    rd_data_b,
  input  logic                lock_en,
  input  logic [ADDR_W-1:0]   lock_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                lock_err
);

  localparam logic [WIDTH-1:0] RESET_WORD_C = WIDTH'(RESET_VALUE);

  // Mode 11 places the right-aligned byte into bits[15:8]; other bits keep old_word.
  function automatic logic [WIDTH-1:0] merge_write(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [1:0]       size);
    logic [WIDTH-1:0] mask_v;
    logic [WIDTH-1:0] data_v;
    case (size)
      2'b00: begin
        mask_v = '1;
        data_v = new_word;
      end
      2'b01: begin
        mask_v = WIDTH'(16'hFFFF);
        data_v = new_word;
      end
      2'b10: begin
        mask_v = WIDTH'(16'h00FF);
        data_v = new_word;
      end
      2'b11: begin
        mask_v = WIDTH'(16'hFF00);
        data_v = WIDTH'({new_word[7:0], 8'h00});
      end
      default: begin
        mask_v = '0;
        data_v = '0;
      end
    endcase
    return (old_word & ~mask_v) | (data_v & mask_v);
  endfunction

  logic [WIDTH-1:0]    regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic                lock_err_r;
  logic [WIDTH-1:0]    rd_data_a_r;
  logic [WIDTH-1:0]    rd_data_b_r;

  logic [WIDTH-1:0]    wr_word_s;
  logic [NUM_REGS-1:0] busy_next_s;
  logic                lock_err_s;
  logic [WIDTH-1:0]    rd_next_a_s;
  logic [WIDTH-1:0]    rd_next_b_s;

  // Next-state: merged write word, scoreboard update (lock after write so lock wins), reads.
  always_comb begin
    wr_word_s   = merge_write(regs_r[wr_addr], wr_data, wr_size);
    busy_next_s = busy_r;
    if (wr_en) begin
      busy_next_s[wr_addr] = 1'b0;
    end else begin
      busy_next_s[wr_addr] = busy_r[wr_addr];
    end
    if (lock_en) begin
      busy_next_s[lock_addr] = 1'b1;
    end else begin
      busy_next_s[lock_addr] = busy_next_s[lock_addr];
    end
    lock_err_s = lock_en && busy_r[lock_addr] && !(wr_en && (wr_addr == lock_addr));
    if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_next_a_s = wr_word_s;
    end else begin
      rd_next_a_s = regs_r[rd_addr_a];
    end
    if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_next_b_s = wr_word_s;
    end else begin
      rd_next_b_s = regs_r[rd_addr_b];
    end
  end

  // State registers; reset discards any same-cycle write or lock.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_WORD_C;
      end
      busy_r      <= '0;
      lock_err_r  <= 1'b0;
      rd_data_a_r <= '0;
      rd_data_b_r <= '0;
    end else begin
      if (wr_en) begin
        regs_r[wr_addr] <= wr_word_s;
      end
      busy_r      <= busy_next_s;
      lock_err_r  <= lock_err_s;
      rd_data_a_r <= rd_next_a_s;
      rd_data_b_r <= rd_next_b_s;
    end
  end

  assign rd_data_a = rd_data_a_r;
  assign rd_data_b = rd_data_b_r;
  assign busy      = busy_r;
  assign lock_err  = lock_err_r;

endmodule

// File: tb/tb_gp_register_file.sv
// Bench for gp_register_file: directed vector table, randomized run against a
// behavioural model, and a small 16-bit/4-register instance.
module tb_gp_register_file;

  logic        clock;
  logic        reset, wr_en, lock_en;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b, lock_addr;
  logic [1:0]  wr_size;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic [7:0]  busy;
  logic        lock_err;

  logic        s_reset, s_wr_en, s_lock_en;
  logic [1:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b, s_lock_addr, s_wr_size;
  logic [15:0] s_wr_data, s_rd_data_a, s_rd_data_b;
  logic [3:0]  s_busy;
  logic        s_lock_err;

  int checks = 0;
  int errors = 0;

  gp_register_file dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .lock_en(lock_en),
    .lock_addr(lock_addr), .busy(busy), .lock_err(lock_err)
  );

  gp_register_file #(.WIDTH(16), .NUM_REGS(4), .ADDR_W(2)) dut16 (
    .clock(clock), .reset(s_reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_size(s_wr_size),
    .wr_data(s_wr_data), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
    .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .lock_en(s_lock_en),
    .lock_addr(s_lock_addr), .busy(s_busy), .lock_err(s_lock_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [1:0]  ws;
    logic [31:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        le;
    logic [2:0]  la;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [7:0]  exp_busy;
    logic        exp_err;
  } vec_t;

  vec_t vecs [17];

  // Reference model state
  logic [31:0] m_regs [8];
  logic [7:0]  m_busy;
  logic        m_err;
  logic [31:0] m_rda, m_rdb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic we, logic [2:0] wa, logic [1:0] ws,
                              logic [31:0] wd, logic [2:0] ra, logic [2:0] rb,
                              logic le, logic [2:0] la, logic [31:0] ea,
                              logic [31:0] eb, logic [7:0] ebusy, logic eerr);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.ws = ws; v.wd = wd; v.ra = ra; v.rb = rb;
    v.le = le; v.la = la; v.exp_a = ea; v.exp_b = eb; v.exp_busy = ebusy; v.exp_err = eerr;
    return v;
  endfunction

  function automatic logic [31:0] model_write(logic [31:0] old, logic [31:0] d, logic [1:0] ws);
    case (ws)
      2'b00:   return d;
      2'b01:   return {old[31:16], d[15:0]};
      2'b10:   return {old[31:8], d[7:0]};
      default: return {old[31:16], d[7:0], old[7:0]};
    endcase
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0] nregs [8];
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0000_0888;
      m_busy = 8'h00; m_err = 1'b0; m_rda = 32'h0; m_rdb = 32'h0;
    end else begin
      for (int i = 0; i < 8; i++) nregs[i] = m_regs[i];
      if (wr_en) nregs[wr_addr] = model_write(m_regs[wr_addr], wr_data, wr_size);
      m_rda = nregs[rd_addr_a];
      m_rdb = nregs[rd_addr_b];
      m_err = lock_en && m_busy[lock_addr] && !(wr_en && wr_addr == lock_addr);
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (lock_en) m_busy[lock_addr] = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = nregs[i];
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic s_drive(logic rst, logic we, logic [1:0] wa, logic [1:0] ws, logic [15:0] wd,
                         logic [1:0] ra, logic [1:0] rb);
    s_reset = rst; s_wr_en = we; s_wr_addr = wa; s_wr_size = ws; s_wr_data = wd;
    s_rd_addr_a = ra; s_rd_addr_b = rb; s_lock_en = 1'b0; s_lock_addr = 2'd0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_size = 2'b00; wr_data = 32'h0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0; lock_en = 1'b0; lock_addr = 3'd0;
    s_drive(1'b1, 1'b0, 2'd0, 2'b00, 16'h0, 2'd0, 2'd0);

    //            rst  we   wa    ws     wd             ra    rb    le   la    exp_a          exp_b          busy   err
    vecs[0]  = mk(1'b1,1'b0,3'd0,2'b00,32'h0000_0000,3'd0,3'd7,1'b0,3'd0,32'h0000_0000,32'h0000_0000,8'h00,1'b0);
    vecs[1]  = mk(1'b0,1'b0,3'd0,2'b00,32'h0000_0000,3'd0,3'd7,1'b0,3'd0,32'h0000_0888,32'h0000_0888,8'h00,1'b0);
    vecs[2]  = mk(1'b0,1'b1,3'd3,2'b00,32'hDEAD_BEEF,3'd3,3'd3,1'b0,3'd0,32'hDEAD_BEEF,32'hDEAD_BEEF,8'h00,1'b0);
    vecs[3]  = mk(1'b0,1'b1,3'd3,2'b10,32'hFFFF_FF11,3'd3,3'd0,1'b0,3'd0,32'hDEAD_BE11,32'h0000_0888,8'h00,1'b0);
    vecs[4]  = mk(1'b0,1'b1,3'd3,2'b11,32'hAAAA_BB22,3'd3,3'd3,1'b0,3'd0,32'hDEAD_2211,32'hDEAD_2211,8'h00,1'b0);
    vecs[5]  = mk(1'b0,1'b1,3'd3,2'b01,32'h5555_3344,3'd3,3'd3,1'b0,3'd0,32'hDEAD_3344,32'hDEAD_3344,8'h00,1'b0);
    vecs[6]  = mk(1'b0,1'b0,3'd3,2'b00,32'h0000_0000,3'd3,3'd1,1'b0,3'd0,32'hDEAD_3344,32'h0000_0888,8'h00,1'b0);
    vecs[7]  = mk(1'b0,1'b1,3'd2,2'b00,32'h1234_5678,3'd2,3'd2,1'b0,3'd0,32'h1234_5678,32'h1234_5678,8'h00,1'b0);
    vecs[8]  = mk(1'b0,1'b0,3'd0,2'b00,32'h0000_0000,3'd2,3'd3,1'b1,3'd5,32'h1234_5678,32'hDEAD_3344,8'h20,1'b0);
    vecs[9]  = mk(1'b0,1'b0,3'd0,2'b00,32'h0000_0000,3'd2,3'd3,1'b1,3'd5,32'h1234_5678,32'hDEAD_3344,8'h20,1'b1);
    vecs[10] = mk(1'b0,1'b0,3'd0,2'b00,32'h0000_0000,3'd2,3'd3,1'b0,3'd5,32'h1234_5678,32'hDEAD_3344,8'h20,1'b0);
    vecs[11] = mk(1'b0,1'b1,3'd5,2'b00,32'hCAFE_0005,3'd5,3'd2,1'b0,3'd0,32'hCAFE_0005,32'h1234_5678,8'h00,1'b0);
    vecs[12] = mk(1'b0,1'b1,3'd5,2'b00,32'h0BAD_F00D,3'd5,3'd5,1'b1,3'd5,32'h0BAD_F00D,32'h0BAD_F00D,8'h20,1'b0);
    vecs[13] = mk(1'b0,1'b1,3'd5,2'b00,32'h1111_2222,3'd5,3'd3,1'b1,3'd5,32'h1111_2222,32'hDEAD_3344,8'h20,1'b0);
    vecs[14] = mk(1'b0,1'b0,3'd5,2'b00,32'hFFFF_FFFF,3'd5,3'd1,1'b0,3'd1,32'h1111_2222,32'h0000_0888,8'h20,1'b0);
    vecs[15] = mk(1'b1,1'b1,3'd1,2'b00,32'hFFFF_FFFF,3'd1,3'd1,1'b1,3'd1,32'h0000_0000,32'h0000_0000,8'h00,1'b0);
    vecs[16] = mk(1'b0,1'b0,3'd0,2'b00,32'h0000_0000,3'd1,3'd5,1'b0,3'd0,32'h0000_0888,32'h0000_0888,8'h00,1'b0);

    for (int i = 0; i < 17; i++) begin
      reset = vecs[i].rst; wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_size = vecs[i].ws;
      wr_data = vecs[i].wd; rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      lock_en = vecs[i].le; lock_addr = vecs[i].la;
      tick();
      check($sformatf("vec%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
      check($sformatf("vec%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
      check($sformatf("vec%0d busy", i), {24'h0, busy}, {24'h0, vecs[i].exp_busy});
      check($sformatf("vec%0d lock_err", i), {31'h0, lock_err}, {31'h0, vecs[i].exp_err});
    end

    // Randomized run against the model, starting from a reset.
    for (int i = 0; i < 400; i++) begin
      reset     = (i == 0) || ($urandom_range(0, 59) == 0);
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 3'($urandom_range(0, 7));
      wr_size   = 2'($urandom_range(0, 3));
      wr_data   = $urandom;
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 3'($urandom_range(0, 7));
      lock_en   = ($urandom_range(0, 2) == 0);
      lock_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      model_step();
      tick();
      check("rand rd_data_a", rd_data_a, m_rda);
      check("rand rd_data_b", rd_data_b, m_rdb);
      check("rand busy", {24'h0, busy}, {24'h0, m_busy});
      check("rand lock_err", {31'h0, lock_err}, {31'h0, m_err});
    end
    reset = 1'b0; wr_en = 1'b0; lock_en = 1'b0;

    // Narrow instance: WIDTH=16, NUM_REGS=4.
    s_drive(1'b1, 1'b1, 2'd1, 2'b00, 16'hFFFF, 2'd0, 2'd3);
    tick();
    check("w16 reset rd_a", {16'h0, s_rd_data_a}, 32'h0000_0000);
    check("w16 reset busy", {28'h0, s_busy}, 32'h0000_0000);
    s_drive(1'b0, 1'b0, 2'd0, 2'b00, 16'h0, 2'd0, 2'd3);
    tick();
    check("w16 resetval rd_a", {16'h0, s_rd_data_a}, 32'h0000_0888);
    check("w16 resetval rd_b", {16'h0, s_rd_data_b}, 32'h0000_0888);
    s_drive(1'b0, 1'b1, 2'd1, 2'b00, 16'hABCD, 2'd1, 2'd1);
    tick();
    check("w16 full write thru", {16'h0, s_rd_data_a}, 32'h0000_ABCD);
    s_drive(1'b0, 1'b0, 2'd0, 2'b00, 16'h0, 2'd1, 2'd2);
    tick();
    check("w16 full write rd_a", {16'h0, s_rd_data_a}, 32'h0000_ABCD);
    check("w16 other reg rd_b", {16'h0, s_rd_data_b}, 32'h0000_0888);
    s_drive(1'b0, 1'b1, 2'd1, 2'b11, 16'hFFEF, 2'd0, 2'd0);
    tick();
    s_drive(1'b0, 1'b0, 2'd0, 2'b00, 16'h0, 2'd1, 2'd1);
    tick();
    check("w16 mode11 rd_a", {16'h0, s_rd_data_a}, 32'h0000_EFCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
